output_port: RTL

Per-direction output stage of the router. It receives packets from the internal crossbar (`enq` / `d_in`) into one single-entry buffer per virtual channel (VC). During the external phase it transmits them on the outgoing link with a send/ready handshake. It returns per-VC full flags to the crossbar arbitration. One instance sits behind each of the N, S, E, W and PE crossbar outputs.

---
 rtl/output_port.sv | 106 ++++++++++
 1 files changed

// File: rtl/output_port.sv
// output_port
//   Per-direction output stage of the router. Packets arriving from the
//   crossbar are held in one single-entry buffer per virtual channel (VC 0/1).
//   During the external phase the buffer selected by `polarity` is offered on
//   the outgoing link with a send/ready handshake. Per-VC occupancy flags go
//   back to the crossbar so it can mask its grants.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous, active-low
//   phase_internal : 1 = crossbar write phase, 0 = link transmit phase
//   polarity       : VC eligible for link transmit this cycle
//   enq, d_in      : crossbar write strobe and packet (d_in[VC_BIT] picks VC)
//   outbuf_full    : registered per-VC occupancy
//   so, dout       : link valid and data (dout = buffer[polarity] always)
//   ri             : downstream ready
//   tx_cnt0/1      : packets sent per VC, wrapping
//   stall_cnt      : external-phase cycles blocked by ri==0, saturating
//   drop_err       : sticky, set when a write targets an occupied buffer
module output_port #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phase_internal,
  input  logic              polarity,
  input  logic              enq,
  input  logic [DATA_W-1:0] d_in,
  output logic [1:0]        outbuf_full,
  output logic              so,
  output logic [DATA_W-1:0] dout,
  input  logic              ri,
  output logic [CNT_W-1:0]  tx_cnt0,
  output logic [CNT_W-1:0]  tx_cnt1,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              drop_err
);

  logic [1:0]        full_reg;
  logic [DATA_W-1:0] buf_reg    [2];
  logic [CNT_W-1:0]  tx_cnt_reg [2];
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              drop_err_reg;

  logic       wr_vc;
  logic       wr_ok;
  logic       wr_drop;
  logic       stall;
  logic [1:0] wr_hit;
  logic [1:0] tx_hit;

  assign wr_vc   = d_in[VC_BIT];
  // Writes only happen in the internal phase and sends only in the external
  // phase, so a buffer can never be filled and drained on the same edge.
  assign wr_ok   = phase_internal & enq & ~full_reg[wr_vc];
  assign wr_drop = phase_internal & enq &  full_reg[wr_vc];

  assign so    = ~phase_internal & full_reg[polarity] &  ri;
  assign stall = ~phase_internal & full_reg[polarity] & ~ri;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc_decode
      assign wr_hit[gi] = wr_ok & (wr_vc == 1'(gi));
      assign tx_hit[gi] = so & (polarity == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_reg      <= '0;
      stall_cnt_reg <= '0;
      drop_err_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i]    <= '0;
        tx_cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_hit[i]) begin
          buf_reg[i]  <= d_in;
          full_reg[i] <= 1'b1;
        end else if (tx_hit[i]) begin
          full_reg[i]   <= 1'b0;
          tx_cnt_reg[i] <= tx_cnt_reg[i] + CNT_W'(1);
        end
      end
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (wr_drop) begin
        drop_err_reg <= 1'b1;
      end
    end
  end

  assign outbuf_full = full_reg;
  assign dout        = buf_reg[polarity];
  assign tx_cnt0     = tx_cnt_reg[0];
  assign tx_cnt1     = tx_cnt_reg[1];
  assign stall_cnt   = stall_cnt_reg;
  assign drop_err    = drop_err_reg;

endmodule
